// File: rtl/oled_pixel_streamer.sv
// Scans a WIDTH x HEIGHT raster, fetches RGB565 pixels from a combinational generator
// and shifts each one MSB-first to the OLED panel over a 4-wire SPI link.
module oled_pixel_streamer #(
    parameter int WIDTH      = 96,
    parameter int HEIGHT     = 64,
    parameter int CLK_DIV    = 4,
    parameter int FRAME_GAP  = 1000,
    parameter int POR_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [6:0]  x,
    output logic [5:0]  y,
    input  logic [15:0] oled_data,
    output logic        sclk,
    output logic        sdin,
    output logic        cs_n,
    output logic        dc,
    output logic        frame_begin,
    output logic        busy
);

    localparam int POR_W = $clog2(POR_CYCLES + 1);
    localparam int GAP_W = $clog2(FRAME_GAP + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [6:0]       X_LAST   = 7'(WIDTH - 1);
    localparam logic [5:0]       Y_LAST   = 6'(HEIGHT - 1);

    typedef enum logic [2:0] {
        ST_RESET_WAIT,
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_FRAME_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [POR_W-1:0]   por_cnt_q, por_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               phase_q, phase_d;
    logic [3:0]         bit_q, bit_d;
    logic [15:0]        shreg_q, shreg_d;
    logic [6:0]         x_q, x_d;
    logic [5:0]         y_q, y_d;
    logic               sclk_q, sclk_d;
    logic               sdin_q, sdin_d;
    logic               cs_n_q, cs_n_d;
    logic               last_pixel;

    assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET_WAIT;
            por_cnt_q <= '0;
            gap_cnt_q <= '0;
            div_cnt_q <= '0;
            phase_q   <= 1'b0;
            bit_q     <= 4'd0;
            shreg_q   <= 16'd0;
            x_q       <= 7'd0;
            y_q       <= 6'd0;
            sclk_q    <= 1'b0;
            sdin_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            por_cnt_q <= por_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            x_q       <= x_d;
            y_q       <= y_d;
            sclk_q    <= sclk_d;
            sdin_q    <= sdin_d;
            cs_n_q    <= cs_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        por_cnt_d = por_cnt_q;
        gap_cnt_d = gap_cnt_q;
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        x_d       = x_q;
        y_d       = y_q;
        sclk_d    = sclk_q;
        sdin_d    = sdin_q;
        cs_n_d    = cs_n_q;

        case (state_q)
            ST_RESET_WAIT: begin
                if (por_cnt_q == POR_LAST) begin
                    por_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    por_cnt_d = por_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (enable) begin
                    x_d     = 7'd0;
                    y_d     = 6'd0;
                    cs_n_d  = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shreg_d   = oled_data;
                sdin_d    = oled_data[15];
                bit_d     = 4'd15;
                div_cnt_d = '0;
                phase_d   = 1'b0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (div_cnt_q != DIV_LAST) begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end else if (!phase_q) begin
                    div_cnt_d = '0;
                    phase_d   = 1'b1;
                    sclk_d    = 1'b1;
                end else begin
                    div_cnt_d = '0;
                    phase_d   = 1'b0;
                    sclk_d    = 1'b0;
                    if (bit_q != 4'd0) begin
                        bit_d  = bit_q - 4'd1;
                        sdin_d = shreg_q[bit_q - 4'd1];
                    end else begin
                        if (x_q == X_LAST) begin
                            x_d = 7'd0;
                            y_d = (y_q == Y_LAST) ? 6'd0 : y_q + 6'd1;
                        end else begin
                            x_d = x_q + 7'd1;
                        end
                        // The IDLE cycle that follows the gap also keeps cs_n high,
                        // so the gap state itself lasts one cycle less than FRAME_GAP.
                        if (last_pixel) begin
                            cs_n_d    = 1'b1;
                            gap_cnt_d = GAP_W'(1);
                            state_d   = (FRAME_GAP > 1) ? ST_FRAME_GAP : ST_IDLE;
                        end else if (!enable) begin
                            cs_n_d  = 1'b1;
                            x_d     = 7'd0;
                            y_d     = 6'd0;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
            ST_FRAME_GAP: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RESET_WAIT;
            end
        endcase
    end

    assign x           = x_q;
    assign y           = y_q;
    assign sclk        = sclk_q;
    assign sdin        = sdin_q;
    assign cs_n        = cs_n_q;
    assign dc          = 1'b1;
    assign frame_begin = (state_q == ST_LOAD) && (x_q == 7'd0) && (y_q == 6'd0);
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_SHIFT);

endmodule
